// File: rtl/stack_burst_ctrl.sv
// stack_burst_ctrl: burst save/restore of a register-file window to a hardware stack.
// Define STACK_BURST_GUARD_EN to enable occupancy checking, saturating depth and ovf/unf interrupts.
module stack_burst_ctrl #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 15,
    parameter int DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_save,
    input  logic        start_restore,
    input  logic        hold,
    input  logic        clear,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stk_push,
    output logic [31:0] stk_d,
    output logic        stk_pop,
    input  logic [31:0] stk_q,
    output logic [10:0] depth,
    output logic        busy,
    output logic        done,
    output logic        ovf_irq,
    output logic        unf_irq
);
    localparam int N  = LAST_REG - FIRST_REG + 1;
    localparam int IW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  idx, idx_nx;
    logic           pv, pv_nx, last, ovf_chk, unf_chk;
    logic [3:0]     raddr_q;
    logic [10:0]    depth_nx;

`ifdef STACK_BURST_GUARD_EN
    localparam bit GUARD = 1'b1;
    assign depth_nx = stk_push ? (depth == 11'(DEPTH) ? depth : depth + 11'd1)
                    : stk_pop  ? (depth == 11'd0 ? depth : depth - 11'd1) : depth;
`else
    localparam bit GUARD = 1'b0;
    assign depth_nx = depth + 11'(stk_push) - 11'(stk_pop);
`endif

    assign ovf_chk = GUARD && (12'(depth) + 12'(N) > 12'(DEPTH));
    assign unf_chk = GUARD && (depth < 11'(N));
    assign last    = idx == IW'(N);
    assign busy    = state != IDLE;
    // While frozen, keep presenting the last issued address so rf_rdata still matches the pending push.
    assign rf_raddr = state == IDLE ? 4'd0 : (hold || last) ? raddr_q : 4'(FIRST_REG + int'(idx));
    assign stk_d    = stk_push ? rf_rdata : 32'd0;
    assign rf_waddr = rf_we ? 4'(LAST_REG + 1 - int'(idx)) : 4'd0;
    assign rf_wdata = rf_we ? stk_q : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            pv      <= 1'b0;
            depth   <= 11'd0;
            raddr_q <= 4'd0;
            ovf_irq <= 1'b0;
            unf_irq <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            pv      <= pv_nx;
            depth   <= depth_nx;
            raddr_q <= rf_raddr;
            ovf_irq <= state == IDLE && start_save && ovf_chk;
            unf_irq <= state == IDLE && !start_save && start_restore && unf_chk;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        pv_nx    = pv;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        rf_we    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start_save && !ovf_chk)
                    state_nx = SAVE;
                else if (!start_save && start_restore && !unf_chk)
                    state_nx = RESTORE;
            end
            default: begin
                if (clear) begin
                    // A word already popped is gone from the stack, so its write-back still lands.
                    rf_we    = state == RESTORE && pv;
                    state_nx = IDLE;
                    idx_nx   = '0;
                    pv_nx    = 1'b0;
                end else if (!hold) begin
                    stk_push = state == SAVE && pv;
                    stk_pop  = state == RESTORE && !last;
                    rf_we    = state == RESTORE && pv;
                    done     = last;
                    state_nx = last ? IDLE : state;
                    idx_nx   = last ? '0 : idx + IW'(1);
                    pv_nx    = !last;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_stack_burst_ctrl.sv
// tb_stack_burst_ctrl: directed burst table, reset/guard sequences and randomized traffic against a cycle model.
module tb_stack_burst_ctrl;
    localparam int FIRST = 1;
    localparam int LAST  = 15;
    localparam int N     = LAST - FIRST + 1;
    localparam int DEPTH = 1024;
`ifdef STACK_BURST_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_save = 1'b0, start_restore = 1'b0, hold = 1'b0, clear = 1'b0;
    logic [3:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata, stk_d, stk_q;
    logic        rf_we, stk_push, stk_pop, busy, done, ovf_irq, unf_irq;
    logic [10:0] depth;

    int checks = 0;
    int errors = 0;

    stack_burst_ctrl dut (
        .clk(clk), .reset(reset), .start_save(start_save), .start_restore(start_restore),
        .hold(hold), .clear(clear), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stk_push(stk_push), .stk_d(stk_d),
        .stk_pop(stk_pop), .stk_q(stk_q), .depth(depth), .busy(busy), .done(done),
        .ovf_irq(ovf_irq), .unf_irq(unf_irq)
    );

    always #5 clk = ~clk;

    // Environment: register file with one-cycle read latency, and stack memory.
    logic [31:0] rf_mem [16];
    logic        init_req = 1'b1;
    logic [31:0] init_base = 32'h100;
    logic [31:0] stk_mem [2048] = '{default: 32'd0};
    logic [10:0] sp;

    always @(posedge clk) begin
        rf_rdata <= rf_mem[rf_raddr];
        if (init_req)
            for (int i = 0; i < 16; i++) rf_mem[i] <= init_base + 32'(i);
        else if (rf_we)
            rf_mem[rf_waddr] <= rf_wdata;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= 11'd0;
        end else if (stk_push) begin
            stk_mem[sp] <= stk_d;
            sp <= sp + 11'd1;
        end else if (stk_pop) begin
            stk_q <= stk_mem[sp - 11'd1];
            sp <= sp - 11'd1;
        end
    end

    // Reference model: burst kind plus count of active cycles, and a LIFO of saved values.
    int          m_mode = 0;
    int          m_k = 0;
    logic [10:0] m_depth = 11'd0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;
    logic [31:0] m_q [$];
    logic [31:0] m_popv = 32'd0;
    logic        e_busy, e_done, e_push, e_pop, e_we, e_raddr_v;
    logic [3:0]  e_raddr, e_waddr;
    logic [31:0] e_d;

    always_comb begin
        e_busy    = m_mode != 0;
        e_push    = m_mode == 1 && !hold && !clear && m_k >= 2;
        e_pop     = m_mode == 2 && !hold && !clear && m_k <= N;
        e_we      = m_mode == 2 && (clear || !hold) && m_k >= 2;
        e_done    = m_mode != 0 && !hold && !clear && m_k == N + 1;
        e_raddr_v = m_mode != 0 && !hold && !clear && m_k <= N;
        e_raddr   = 4'(FIRST + m_k - 1);
        e_waddr   = 4'(LAST - (m_k - 2));
        e_d       = rf_mem[4'(FIRST + m_k - 2)];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= 0;
            m_k <= 0;
            m_depth <= 11'd0;
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
            m_q.delete();
        end else begin
            int d;
            if (e_push) m_q.push_back(e_d);
            if (e_pop) m_popv <= (m_q.size() > 0) ? m_q.pop_back() : 32'd0;
            d = int'(m_depth) + int'(e_push) - int'(e_pop);
            if (GUARD) d = d < 0 ? 0 : d > DEPTH ? DEPTH : d;
            m_depth <= 11'(d);
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
            if (m_mode == 0) begin
                if (start_save) begin
                    if (GUARD && int'(m_depth) + N > DEPTH) m_ovf <= 1'b1;
                    else begin m_mode <= 1; m_k <= 1; end
                end else if (start_restore) begin
                    if (GUARD && int'(m_depth) < N) m_unf <= 1'b1;
                    else begin m_mode <= 2; m_k <= 1; end
                end
            end else if (clear) begin
                m_mode <= 0;
            end else if (!hold) begin
                if (m_k == N + 1) m_mode <= 0;
                else m_k <= m_k + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("stk_push", stk_push, e_push);
        chk("stk_pop", stk_pop, e_pop);
        chk("rf_we", rf_we, e_we);
        chk("depth", depth, m_depth);
        chk("ovf_irq", ovf_irq, m_ovf);
        chk("unf_irq", unf_irq, m_unf);
        if (e_push) chk("stk_d", stk_d, e_d);
        if (e_raddr_v) chk("rf_raddr", rf_raddr, e_raddr);
        if (e_we) begin
            chk("rf_waddr", rf_waddr, e_waddr);
            chk("rf_wdata", rf_wdata, m_popv);
        end
    endtask

    typedef struct {
        int op;
        int hold_at;
        int hold_len;
        int clear_at;
        int exp_done;
        int exp_end;
        int exp_xf;
        int exp_depth;
    } vec_t;

    function automatic vec_t mk(int op, int ha, int hl, int ca, int dn, int en, int xf, int dp);
        vec_t v;
        v.op = op; v.hold_at = ha; v.hold_len = hl; v.clear_at = ca;
        v.exp_done = dn; v.exp_end = en; v.exp_xf = xf; v.exp_depth = dp;
        return v;
    endfunction

    task automatic run_burst(input vec_t v);
        int done_c = 0, xf = 0, end_c = 0;
        start_save = v.op == 0;
        start_restore = v.op == 1;
        @(posedge clk); #1;
        start_save = 1'b0;
        start_restore = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            hold = v.hold_at != 0 && c >= v.hold_at && c < v.hold_at + v.hold_len;
            clear = c == v.clear_at;
            @(negedge clk);
            check_outputs();
            if (!busy) begin
                end_c = c;
                break;
            end
            if (done) done_c = c;
            if (stk_push || rf_we) xf++;
            @(posedge clk); #1;
        end
        hold = 1'b0;
        clear = 1'b0;
        chk("burst_end_cycle", end_c, v.exp_end);
        chk("burst_done_cycle", done_c, v.exp_done);
        chk("burst_transfers", xf, v.exp_xf);
        chk("burst_depth", depth, v.exp_depth);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        tbl[0] = mk(0, 0,  0, 0,  16, 17, 15, 15);
        tbl[1] = mk(1, 0,  0, 0,  16, 17, 15, 0);
        tbl[2] = mk(0, 5,  3, 0,  19, 20, 15, 15);
        tbl[3] = mk(1, 0,  0, 6,  0,  7,  5,  10);
        tbl[4] = mk(0, 16, 2, 0,  18, 19, 15, 25);
        tbl[5] = mk(1, 1,  1, 0,  17, 18, 15, 10);
        tbl[6] = mk(0, 0,  0, 1,  0,  2,  0,  10);
        tbl[7] = mk(0, 0,  0, 16, 0,  17, 14, 24);

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_depth", depth, 0);
        chk("rst_raddr", rf_raddr, 0);
        chk("rst_strobes", {stk_push, stk_pop, rf_we, done, ovf_irq, unf_irq}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        init_req = 1'b0;
        reset = 1'b1;
        idle_cycle();

        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                init_base = 32'hDEAD_0000;
                init_req = 1'b1;
                @(posedge clk); #1;
                init_req = 1'b0;
            end
            run_burst(tbl[i]);
            if (i == 1)
                for (int r = FIRST; r <= LAST; r++) chk("restored_reg", rf_mem[r], 32'h100 + 32'(r));
        end

        start_save = 1'b1;
        @(posedge clk); #1;
        start_save = 1'b0;
        repeat (7) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_depth", depth, 0);
        chk("arst_raddr", rf_raddr, 0);
        chk("arst_strobes", {stk_push, stk_pop, rf_we, done, ovf_irq, unf_irq}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_burst(mk(0, 0, 0, 0, 16, 17, 15, 15));

        for (int i = 0; i < 500; i++) begin
            start_save = ($urandom % 8 == 0) && (GUARD || m_depth < 11'd1900);
            start_restore = ($urandom % 8 == 0) && (GUARD || m_depth >= 11'(N));
            hold = $urandom % 5 == 0;
            clear = $urandom % 25 == 0;
            @(negedge clk);
            check_outputs();
            @(posedge clk); #1;
        end
        start_save = 1'b0;
        start_restore = 1'b0;
        hold = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 40 && busy; i++) idle_cycle();

        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
`ifdef STACK_BURST_GUARD_EN
        start_restore = 1'b1;
        @(posedge clk); #1;
        start_restore = 1'b0;
        @(negedge clk);
        check_outputs();
        chk("unf_pulse", unf_irq, 1);
        chk("unf_no_start", {busy, stk_pop}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("unf_one_cycle", unf_irq, 0);
        @(posedge clk); #1;
        for (int j = 0; j < 67; j++) run_burst(mk(0, 0, 0, 0, 16, 17, 15, 15 * (j + 1)));
        run_burst(mk(0, 0, 0, 12, 0, 13, 10, 1015));
        start_save = 1'b1;
        @(posedge clk); #1;
        start_save = 1'b0;
        @(negedge clk);
        check_outputs();
        chk("ovf_pulse", ovf_irq, 1);
        chk("ovf_no_start", {busy, stk_push}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ovf_one_cycle", ovf_irq, 0);
        chk("ovf_depth", depth, 1015);
`else
        run_burst(mk(1, 0, 0, 0, 16, 17, 15, 2033));
        idle_cycle();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
